rtc_button_ctrl: RTL
====================

# rtc_button_ctrl

Input-side companion to the RTC display driver. It conditions the three active-low time-set push buttons and the manual-set switch from the DE2-115 board: synchronises, debounces on a 1 kHz sample tick, and edge-detects them. It then issues one-cycle increment pulses for the hours, minutes and seconds columns, with auto-repeat while a button is held. The pulses feed the HH:MM:SS BCD counters, which the display driver renders.

## Interface
- TICK_DIV, 50000, clock50MHz cycles per debounce sample tick (1 kHz at 50 MHz); legal range ≥ 2.
- DB_LEN, 8, consecutive identical samples needed to change a debounced level; legal range 2–16.
- HOLD_TICKS, 1000, ticks of continuous hold before auto-repeat starts; legal range ≥ 2.
- REPEAT_TICKS, 250, ticks between auto-repeat pulses; legal range ≥ 1.

Ports:
- clock50MHz  in  1  50 MHz system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- push_button  in  3  raw buttons, active low (0 = pressed): [0] seconds, [1] minutes, [2] hours.
- man_switch  in  1  raw switch: 0 = set mode (buttons active), 1 = run mode.
- inc_sec, inc_min, inc_hr  out  1 each  one-cycle increment pulses.
- buttons_db  out  3  debounced pressed levels (1 = pressed), same bit order as push_button.
- set_mode  out  1  synchronised set-mode level (1 = set mode).

## Operation
- Synchronisation:
  - Two-flop synchroniser on each push_button bit, inverted to active-high "pressed".
  - Two-flop synchroniser on man_switch; set_mode = NOT (synchronised man_switch).
- Tick generator:
  - Counter 0..TICK_DIV-1; tick is high for one cycle when the counter equals TICK_DIV-1, then the counter wraps to 0.
- Debounce, per button:
  - DB_LEN-bit shift register; shifts in the synchronised pressed bit on each tick only.
  - buttons_db[i] sets when the register is all ones and clears when it is all zeros; otherwise it holds.
- Per-button FSM, one per button, all independent:
  - IDLE: when buttons_db rises and set_mode = 1, emit one inc pulse, clear the hold counter, go to HOLD.
  - IDLE: when buttons_db rises and set_mode = 0, go to WAIT_REL with no pulse.
  - HOLD: the hold counter increments on each tick. When it reaches HOLD_TICKS, emit a pulse, clear the counter, go to REPEAT.
  - REPEAT: the counter increments on each tick. When it reaches REPEAT_TICKS, emit a pulse and clear the counter.
  - From HOLD or REPEAT: buttons_db falling goes to IDLE. set_mode falling goes to WAIT_REL; no pulse is emitted that cycle.
  - WAIT_REL: go to IDLE when buttons_db falls. Re-entering set mode while the button is still held never produces a pulse.
- Gating: a pulse is emitted only when set_mode = 1 in the same cycle.
- Simultaneous presses are independent; any combination of inc_* may pulse in the same cycle.
- The hold counter is wide enough for max(HOLD_TICKS, REPEAT_TICKS) and never wraps; it saturates by transition.

## Timing
- Reset values:
  - inc_* = 0, buttons_db = 000, set_mode = 0.
  - Synchronisers hold "released"/run (pressed = 0, man_switch = 1).
  - Shift registers all zero, tick counter 0, hold counters 0, FSMs in IDLE.
- Latency:
  - Raw edge to synchronised pressed bit: 2 cycles.
  - Pressed bit to buttons_db: DB_LEN ticks after it becomes stable, on the tick cycle that completes the run.
  - buttons_db rise to inc pulse: 1 cycle, because the FSM is registered.
- Output pulses are exactly 1 clock50MHz cycle wide.
- Raw man_switch to set_mode: 2 cycles; no debounce on the switch.
- Reset mid-hold returns everything to reset values on the next edge; no pulse is emitted in the reset cycle.
- A bounce shorter than DB_LEN ticks never changes buttons_db.

## Test plan
All scenarios use TICK_DIV=4, DB_LEN=4, HOLD_TICKS=10, REPEAT_TICKS=3.
- Reset: assert reset for 3 cycles with all buttons pressed and man_switch=0 → all outputs 0 during reset; first inc_sec possible only after the full sync + debounce latency.
- Single press: man_switch=0, push_button[0] low for 8 ticks then high → buttons_db[0] rises after 4 stable ticks, exactly one inc_sec pulse 1 cycle later, inc_min = inc_hr = 0.
- Auto-repeat: hold push_button[2] low → inc_hr pulses at debounced-entry, +10, +13, +16, +19 ticks; release after 20 ticks → exactly 5 pulses total, none after release.
- Bounce rejection: toggle push_button[1] with a 3-tick low, 1-tick high pattern for 40 ticks → buttons_db[1] stays 0, zero inc_min pulses.
- Run mode gating: man_switch=1 and press all buttons → no pulses. Switch to man_switch=0 while held → still no pulses. Release and re-press → one pulse each on all three outputs in the same cycle.
- Mode exit mid-repeat: in REPEAT, set man_switch=1 → pulses stop immediately. Returning to set mode while held → no pulses until release.

Source files
------------

// File: rtl/rtc_button_ctrl.sv
// Time-set button conditioner for the RTC: synchronises, debounces and edge-detects
// the three set buttons and the mode switch, then issues increment pulses with auto-repeat.
module rtc_button_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int DB_LEN       = 8,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       clock50MHz,
  input  logic       reset,
  input  logic [2:0] push_button,
  input  logic       man_switch,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hr,
  output logic [2:0] buttons_db,
  output logic       set_mode
);

  localparam int TW     = $clog2(TICK_DIV);
  localparam int HC_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW     = $clog2(HC_MAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_CNT  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] REP_CNT   = HW'(REPEAT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_WAIT_REL
  } btn_state_e;

  logic [2:0]        pb_s1, pb_s2;
  logic              sw_s1, sw_s2;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [DB_LEN-1:0] sh_q [3];
  logic [DB_LEN-1:0] sh_d [3];
  logic [2:0]        db_q;
  btn_state_e        state_q [3];
  btn_state_e        state_d [3];
  logic [HW-1:0]     cnt_q [3];
  logic [HW-1:0]     cnt_d [3];
  logic [2:0]        inc_q, inc_d;

  // Synchronisers idle at "released" and "run" so nothing fires out of reset.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      pb_s1 <= '0;
      pb_s2 <= '0;
      sw_s1 <= 1'b1;
      sw_s2 <= 1'b1;
    end else begin
      pb_s1 <= ~push_button;
      pb_s2 <= pb_s1;
      sw_s1 <= man_switch;
      sw_s2 <= sw_s1;
    end
  end

  assign set_mode = ~sw_s2;
  assign tick     = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock50MHz) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // The debounced level is judged on the post-shift value, so it moves on the completing tick.
  always_comb begin
    for (int i = 0; i < 3; i++) sh_d[i] = {sh_q[i][DB_LEN-2:0], pb_s2[i]};
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sh_q[i] <= '0;
      db_q <= '0;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        sh_q[i] <= sh_d[i];
        if (&sh_d[i])       db_q[i] <= 1'b1;
        else if (~|sh_d[i]) db_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      inc_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      inc_q <= inc_d;
    end
  end

  // IDLE is only ever entered with the button released, so a high level there is a fresh press.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    inc_d = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (db_q[i]) begin
            if (set_mode) begin
              inc_d[i]   = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = S_HOLD;
            end else begin
              state_d[i] = S_WAIT_REL;
            end
          end
        end
        S_HOLD, S_REPEAT: begin
          if (!db_q[i]) begin
            state_d[i] = S_IDLE;
          end else if (!set_mode) begin
            state_d[i] = S_WAIT_REL;
          end else if (cnt_q[i] == ((state_q[i] == S_HOLD) ? HOLD_CNT : REP_CNT)) begin
            inc_d[i]   = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = S_REPEAT;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        S_WAIT_REL: begin
          if (!db_q[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  assign inc_sec    = inc_q[0];
  assign inc_min    = inc_q[1];
  assign inc_hr     = inc_q[2];
  assign buttons_db = db_q;

endmodule
